neural_output_collector: RTL and testbench

//  Consumer end of the accelerator's 8-bit output stream. Accepts one frame of
//  NUM_OUTPUTS signed neuron results via valid/ready, keeps them in a readback buffer,

---
 rtl/neural_output_collector.sv | 119 +++++++++++
 tb/tb_neural_output_collector.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/neural_output_collector.sv
// Collects one frame of signed 8-bit neuron results, tracks the running argmax and
// reports it via valid/ready. Optional macro NEURAL_COLLECTOR_RELU_EN clamps negatives to 0.
module neural_output_collector #(
    parameter int NUM_OUTPUTS = 10,
    parameter int IDX_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [IDX_W-1:0] res_index,
    output logic [7:0]       res_value,
    output logic             frame_err,
    input  logic             err_clear,
    input  logic [IDX_W-1:0] rd_addr,
    output logic [7:0]       rd_data
);
    typedef enum logic {COLLECT = 1'b0, REPORT = 1'b1} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OUTPUTS - 1);

    state_t            state_reg, state_next;
    logic [IDX_W-1:0]  count_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic signed [7:0] max_reg;
    logic signed [7:0] beat_val;
    logic [7:0]        buffer [NUM_OUTPUTS];

    logic accept;
    logic at_last;
    logic frame_end;
    logic new_err;

`ifdef NEURAL_COLLECTOR_RELU_EN
    assign beat_val = in_data[7] ? 8'sd0 : $signed(in_data);
`else
    assign beat_val = $signed(in_data);
`endif

    assign accept    = in_valid & in_ready;
    assign at_last   = (count_reg == LAST_IDX);
    // A frame ends on either the full beat count or an early in_last; any mismatch is an error.
    assign frame_end = in_last | at_last;
    assign new_err   = accept & (in_last ^ at_last);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= COLLECT;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            COLLECT: if (accept && frame_end) state_next = REPORT;
            REPORT:  if (res_ready)           state_next = COLLECT;
            default:                          state_next = COLLECT;
        endcase
    end

    always_comb begin
        in_ready  = (state_reg == COLLECT);
        res_valid = (state_reg == REPORT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
            idx_reg   <= '0;
            max_reg   <= 8'sh80;
            frame_err <= 1'b0;
        end else begin
            if (accept) begin
                // Strict greater-than keeps the lowest index on ties.
                if (count_reg == '0 || beat_val > max_reg) begin
                    max_reg <= beat_val;
                    idx_reg <= count_reg;
                end
                if (!frame_end) begin
                    count_reg <= count_reg + 1'b1;
                end
            end
            if (state_reg == REPORT && res_ready) begin
                count_reg <= '0;
            end
            if (new_err) begin
                frame_err <= 1'b1;
            end else if (err_clear) begin
                frame_err <= 1'b0;
            end
        end
    end

    assign res_index = idx_reg;
    assign res_value = max_reg;

    always_ff @(posedge clk) begin
        if (accept) begin
            buffer[count_reg] <= beat_val;
        end
    end

    // Read-before-write: a same-cycle write to rd_addr is seen on the following read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= 8'h00;
        end else if (rd_addr <= LAST_IDX) begin
            rd_data <= buffer[rd_addr];
        end else begin
            rd_data <= 8'h00;
        end
    end
endmodule

// File: tb/tb_neural_output_collector.sv
// Bench for neural_output_collector: queue-based frame model checked every cycle,
// plus directed frames with literal expectations.
module tb_neural_output_collector;
    localparam int N = 10;
    localparam int W = 4;

    logic         clk       = 1'b0;
    logic         reset     = 1'b1;
    logic         in_valid  = 1'b0;
    logic [7:0]   in_data   = 8'h00;
    logic         in_last   = 1'b0;
    logic         res_ready = 1'b0;
    logic         err_clear = 1'b0;
    logic [W-1:0] rd_addr   = '0;
    logic         in_ready;
    logic         res_valid;
    logic [W-1:0] res_index;
    logic [7:0]   res_value;
    logic         frame_err;
    logic [7:0]   rd_data;

    int checks   = 0;
    int failures = 0;

    int f1[$] = '{3, -5, 7, 7, 1, 0, 2, -1, 4, 6};
    int f2[$] = '{-128, -128, -128, -128, -128, -128, -128, -128, -128, -128};
    int f4[$] = '{5, 5, 5, 5, 5, 5, 5, 5, 5, 5};
    int f5[$] = '{0, 3, 6, 9, 12, 15, 18, 21, 50, 27};

    neural_output_collector #(.NUM_OUTPUTS(N), .IDX_W(W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready), .res_valid(res_valid),
        .res_ready(res_ready), .res_index(res_index), .res_value(res_value),
        .frame_err(frame_err), .err_clear(err_clear), .rd_addr(rd_addr),
        .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int clampv(input int v);
`ifdef NEURAL_COLLECTOR_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    // Model state: frame so far, pending result, sticky error, readback memory.
    int q[$];
    int mem[N];
    bit mem_known[N];
    bit m_rv     = 1'b0;
    int m_idx    = 0;
    int m_val    = -128;
    bit m_err    = 1'b0;
    int m_rd     = 0;
    bit rd_known = 1'b1;

    initial begin : model
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                q.delete();
                m_rv = 1'b0; m_idx = 0; m_val = -128; m_err = 1'b0;
                m_rd = 0; rd_known = 1'b1;
                foreach (mem_known[i]) mem_known[i] = 1'b0;
            end else begin
                bit rv_old, nerr;
                int v, best;
                rv_old = m_rv;
                nerr   = 1'b0;
                if (int'(rd_addr) < N) begin
                    rd_known = mem_known[rd_addr];
                    m_rd     = mem[rd_addr];
                end else begin
                    rd_known = 1'b1;
                    m_rd     = 0;
                end
                if (!rv_old && in_valid) begin
                    v = clampv($signed(in_data));
                    mem[q.size()]       = v;
                    mem_known[q.size()] = 1'b1;
                    q.push_back(v);
                    if (in_last != (q.size() == N)) nerr = 1'b1;
                    if (in_last || q.size() == N) begin
                        best = 0;
                        foreach (q[i]) if (q[i] > q[best]) best = i;
                        m_idx = best;
                        m_val = q[best];
                        m_rv  = 1'b1;
                    end
                end
                if (rv_old && res_ready) begin
                    m_rv = 1'b0;
                    q.delete();
                end
                if (nerr) m_err = 1'b1;
                else if (err_clear) m_err = 1'b0;
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            chk("in_ready", int'(in_ready), int'(!m_rv));
            chk("res_valid", int'(res_valid), int'(m_rv));
            chk("frame_err", int'(frame_err), int'(m_err));
            if (m_rv) begin
                chk("res_index", int'(res_index), m_idx);
                chk("res_value", int'($signed(res_value)), m_val);
            end
            if (rd_known) chk("rd_data", int'($signed(rd_data)), m_rd);
        end
    end

    task automatic beat(input int d, input bit l);
        int t = 0;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("ready_timeout", 0, 1);
        in_valid = 1'b1;
        in_data  = 8'(d);
        in_last  = l;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send(input int vals[$], input int lastpos);
        foreach (vals[i]) beat(vals[i], (i == lastpos));
    endtask

    task automatic take_result();
        int t = 0;
        while (!res_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!res_valid) chk("res_timeout", 0, 1);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    initial begin : stim
        repeat (3) @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_res_index", int'(res_index), 0);
        chk("rst_res_value", int'(res_value), 8'h80);
        chk("rst_frame_err", int'(frame_err), 0);
        chk("rst_rd_data", int'(rd_data), 0);
        reset = 1'b0;
        @(negedge clk);

        // Basic frame, result registered on the last-beat edge.
        send(f1, 9);
        chk("f1_valid", int'(res_valid), 1);
        chk("f1_index", int'(res_index), 2);
        chk("f1_value", int'($signed(res_value)), clampv(7));
        chk("f1_err", int'(frame_err), 0);

        // Readback echoes the stream; out-of-range address reads zero.
        for (int a = 0; a < N; a++) begin
            rd_addr = W'(a);
            @(negedge clk);
            chk("rd_f1", int'($signed(rd_data)), clampv(f1[a]));
        end
        rd_addr = 4'd15;
        @(negedge clk);
        chk("rd_oob", int'(rd_data), 0);

        // Host stalls: upstream offers beats that must not be taken.
        in_valid = 1'b1;
        in_data  = 8'd99;
        repeat (10) @(negedge clk);
        chk("stall_ready", int'(in_ready), 0);
        chk("stall_index", int'(res_index), 2);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        in_valid  = 1'b0;
        chk("post_hs_ready", int'(in_ready), 1);
        chk("post_hs_valid", int'(res_valid), 0);

        // All most-negative frame.
        send(f2, 9);
        chk("f2_index", int'(res_index), 0);
        chk("f2_value", int'($signed(res_value)), clampv(-128));
        rd_addr = 4'd5;
        @(negedge clk);
        chk("f2_rd5", int'($signed(rd_data)), clampv(-128));
        take_result();

        // Early in_last; err_clear coincides with the error so set wins.
        beat(1, 1'b0);
        beat(9, 1'b0);
        beat(2, 1'b0);
        err_clear = 1'b1;
        beat(3, 1'b1);
        err_clear = 1'b0;
        chk("f4_index", int'(res_index), 1);
        chk("f4_value", int'($signed(res_value)), 9);
        chk("f4_err", int'(frame_err), 1);
        take_result();
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        chk("f4_err_clr", int'(frame_err), 0);

        // Missing in_last on the final beat, all ties -> lowest index.
        send(f4, -1);
        chk("tie_index", int'(res_index), 0);
        chk("tie_value", int'($signed(res_value)), 5);
        chk("tie_err", int'(frame_err), 1);
        take_result();
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;

        // Reset mid-frame discards the partial frame.
        for (int i = 0; i < 6; i++) beat(100 + i, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_ready", int'(in_ready), 1);
        chk("midrst_value", int'(res_value), 8'h80);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        send(f5, 9);
        chk("f5_index", int'(res_index), 8);
        chk("f5_value", int'($signed(res_value)), 50);
        take_result();
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
